mem_arbiter: RTL and testbench

- Sits directly downstream of the request unit; consumes its registered iREN/dREN/dWEN and returns the ihit/dhit that drop them.
- Arbitrates one shared, variable-latency, single-ported RAM between instruction fetch and data access.
- Data requests win by default; a starvation counter guarantees instruction progress.
- Detects RAM error and timeout, and reports them through a sticky error flag.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency RAM between the
// instruction-fetch and data ports of the request unit.
//
// Handshake: a requester raises iREN or dREN/dWEN and keeps its address and
// write data steady until it sees the matching one-cycle ihit/dhit. The
// request unit drops the request on the edge that ends the hit cycle. The
// arbiter never grants in a response state, so the still-high request seen
// during the hit cycle cannot be granted twice. Every grant ends in exactly
// one hit, even when the RAM reports ERROR or the access times out.
// A reset abandons any access in flight without producing a hit.
module mem_arbiter #(
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err,
  output logic [2:0]  dbg_state
);

  // RAM status encoding presented on ramstate
  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // Wide enough to hold TIMEOUT-1 and STARVE_MAX respectively
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    DRSP = 3'd3,
    IRSP = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;      // cycles spent in the current access state
  logic [SW-1:0] starve;   // consecutive data grants while iREN waited
  logic          req_wr;   // latched op of the data request being served

  logic data_req;
  logic data_wins;
  logic access_done;
  logic access_ok;

  // Grant decision and access completion, evaluated from current inputs
  always_comb begin
    data_req    = dREN | dWEN;
    data_wins   = data_req & (~iREN | (starve < SW'(STARVE_MAX)));
    access_ok   = (ramstate == RAM_ACCESS);
    access_done = access_ok | (ramstate == RAM_ERROR) |
                  (cnt == CW'(TIMEOUT - 1));
  end

  // Arbitration FSM; all outputs, including the RAM drive, are registered
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      req_wr   <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // hits are single-cycle pulses: only the edge entering a response
      // state raises one
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (data_wins) begin
            // ramaddr/ramstore double as the latched request, so later
            // changes on daddr/dstore cannot disturb the access
            req_wr   <= dWEN;
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dWEN ? dstore : 32'd0;
            if (iREN) starve <= starve + SW'(1);
            state    <= DACC;
          end else if (iREN) begin
            req_wr   <= 1'b0;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= iaddr;
            ramstore <= 32'd0;
            starve   <= '0;
            state    <= IACC;
          end
        end

        DACC, IACC: begin
          if (access_done) begin
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            if (access_ok) begin
              if (state == IACC) iload <= ramload;
              else if (!req_wr)  dload <= ramload;
            end else begin
              // ERROR or timeout: loads keep their old value, but the
              // requester still gets its hit so the pipeline moves on
              err <= 1'b1;
            end
            if (state == IACC) begin
              ihit  <= 1'b1;
              state <= IRSP;
            end else begin
              dhit  <= 1'b1;
              state <= DRSP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DRSP, IRSP: begin
          // no grant here: the requester's request is still high this cycle
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // FSM state exposed for debug and checkers
  assign dbg_state = state;

  // RAM_FREE and RAM_BUSY are named for readability; neither ends an access
  logic unused_enc;
  assign unused_enc = ^{RAM_FREE, RAM_BUSY};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int TIMEOUT    = 64;
  localparam int STARVE_MAX = 4;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = RS_FREE;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [2:0]  dbg_state;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int          m_starve;
  logic [31:0] m_dload, m_iload;
  logic        m_err;
  logic [31:0] exp_q[$];   // expected RAM address of each grant, in order

  task automatic model_reset();
    m_starve = 0; m_dload = '0; m_iload = '0; m_err = 1'b0;
    exp_q.delete();
  endtask

  // Who wins given the requests currently driven; records expected address
  task automatic model_grant(output logic is_data);
    if ((dREN || dWEN) && (!iREN || m_starve < STARVE_MAX)) begin
      is_data = 1'b1;
      if (iREN) m_starve = m_starve + 1;
    end else begin
      is_data = 1'b0;
      m_starve = 0;
    end
    exp_q.push_back(is_data ? daddr : iaddr);
  endtask

  // Access ends well only if ACCESS shows within TIMEOUT cycles
  task automatic model_done(input logic is_data, input logic is_wr,
                            input logic [1:0] fin, input int nbusy,
                            input logic [31:0] rd);
    if (fin == RS_ACC && nbusy + 1 <= TIMEOUT) begin
      if (is_data && !is_wr) m_dload = rd;
      else if (!is_data)     m_iload = rd;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  logic        g_ren, g_wen, r_dhit, r_ihit, r_en, p_bad;
  logic [31:0] g_addr, g_store;
  int          g_hold_bad;

  task automatic do_reset();
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ramstate = RS_FREE;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
  endtask

  // One full transaction from IDLE: grant edge, nbusy BUSY cycles, a final
  // cycle with ramstate=fin, then one cycle back in IDLE.
  task automatic drive_txn(input int nbusy, input logic [1:0] fin,
                           input logic [31:0] rd);
    ramstate = RS_FREE;
    @(posedge CLK); #1;
    g_ren = ramREN; g_wen = ramWEN; g_addr = ramaddr; g_store = ramstore;
    g_hold_bad = 0;
    for (int i = 0; i < nbusy; i++) begin
      ramstate = RS_BUSY;
      @(posedge CLK); #1;
      if (ramREN !== g_ren || ramWEN !== g_wen || ramaddr !== g_addr ||
          ramstore !== g_store || dhit !== 1'b0 || ihit !== 1'b0)
        g_hold_bad++;
    end
    ramstate = fin; ramload = rd;
    @(posedge CLK); #1;
    r_dhit = dhit; r_ihit = ihit; r_en = ramREN | ramWEN;
    ramstate = RS_FREE; ramload = $urandom;
    @(posedge CLK); #1;
    p_bad = dhit | ihit | ramREN | ramWEN;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({iload, dload, ramaddr, ramstore, ihit, dhit, ramREN, ramWEN, err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs iload=%h dload=%h ramaddr=%h err=%b", iload, dload, ramaddr, err);
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0 (IDLE)", dbg_state); end
  endtask

  task automatic test_data_read();
    logic is_data;
    do_reset();
    dREN = 1; daddr = 32'h40;
    model_grant(is_data);
    drive_txn(2, RS_ACC, 32'hDEADBEEF);
    model_done(is_data, 1'b0, RS_ACC, 2, 32'hDEADBEEF);
    void'(exp_q.pop_front());
    n_checks++; if (g_ren !== 1'b1 || g_wen !== 1'b0) begin n_fail++; $display("FAIL rd_enables: got ren=%b wen=%b want 1/0", g_ren, g_wen); end
    n_checks++; if (g_addr !== 32'h40) begin n_fail++; $display("FAIL rd_addr: got %h want 00000040", g_addr); end
    n_checks++; if (g_hold_bad !== 0) begin n_fail++; $display("FAIL rd_hold: %0d bad busy cycles want 0", g_hold_bad); end
    n_checks++; if (r_dhit !== 1'b1 || r_ihit !== 1'b0 || r_en !== 1'b0) begin n_fail++; $display("FAIL rd_hit: got dhit=%b ihit=%b en=%b want 1/0/0", r_dhit, r_ihit, r_en); end
    n_checks++; if (dload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_dload: got %h want deadbeef", dload); end
    n_checks++; if (p_bad !== 1'b0) begin n_fail++; $display("FAIL rd_no_regrant: activity seen in idle cycle after hit"); end
    dREN = 0;
  endtask

  task automatic test_simultaneous();
    logic is_data;
    do_reset();
    iREN = 1; iaddr = 32'h0; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    model_grant(is_data);
    drive_txn(1, RS_ACC, 32'h0);
    model_done(is_data, 1'b1, RS_ACC, 1, 32'h0);
    void'(exp_q.pop_front());
    n_checks++; if (g_wen !== 1'b1 || g_ren !== 1'b0 || g_addr !== 32'h80 || g_store !== 32'h12345678) begin
      n_fail++; $display("FAIL sim_first: got wen=%b ren=%b addr=%h store=%h want write 80/12345678", g_wen, g_ren, g_addr, g_store); end
    n_checks++; if (r_dhit !== 1'b1 || r_ihit !== 1'b0) begin n_fail++; $display("FAIL sim_dhit_first: got dhit=%b ihit=%b", r_dhit, r_ihit); end
    n_checks++; if (dload !== 32'h0) begin n_fail++; $display("FAIL sim_write_dload: got %h want 0", dload); end
    dWEN = 0;
    model_grant(is_data);
    drive_txn(0, RS_ACC, 32'hCAFE0001);
    model_done(is_data, 1'b0, RS_ACC, 0, 32'hCAFE0001);
    void'(exp_q.pop_front());
    n_checks++; if (g_ren !== 1'b1 || g_addr !== 32'h0) begin n_fail++; $display("FAIL sim_second: got ren=%b addr=%h want 1/0", g_ren, g_addr); end
    n_checks++; if (r_ihit !== 1'b1 || r_dhit !== 1'b0) begin n_fail++; $display("FAIL sim_ihit_second: got ihit=%b dhit=%b", r_ihit, r_dhit); end
    n_checks++; if (iload !== 32'hCAFE0001) begin n_fail++; $display("FAIL sim_iload: got %h want cafe0001", iload); end
    iREN = 0;
  endtask

  task automatic test_starvation();
    logic is_data;
    logic [31:0] ea, rd;
    do_reset();
    iREN = 1; iaddr = 32'h1000; dREN = 1; daddr = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      rd = $urandom;
      model_grant(is_data);
      drive_txn(0, RS_ACC, rd);
      model_done(is_data, 1'b0, RS_ACC, 0, rd);
      ea = exp_q.pop_front();
      // four data grants, then the instruction, then data again
      n_checks++; if (r_dhit !== (k != 4) || r_ihit !== (k == 4)) begin
        n_fail++; $display("FAIL starve_order[%0d]: got dhit=%b ihit=%b want dhit=%b", k, r_dhit, r_ihit, (k != 4)); end
      n_checks++; if (g_addr !== ea) begin n_fail++; $display("FAIL starve_addr[%0d]: got %h want %h", k, g_addr, ea); end
    end
    n_checks++; if (iload !== m_iload || dload !== m_dload) begin
      n_fail++; $display("FAIL starve_loads: got i=%h d=%h want i=%h d=%h", iload, dload, m_iload, m_dload); end
    iREN = 0; dREN = 0;
  endtask

  task automatic test_timeout();
    logic is_data;
    do_reset();
    dREN = 1; daddr = 32'h10;
    model_grant(is_data); drive_txn(0, RS_ACC, 32'hA5A50001);
    model_done(is_data, 1'b0, RS_ACC, 0, 32'hA5A50001); void'(exp_q.pop_front());
    daddr = 32'h20;
    model_grant(is_data); drive_txn(TIMEOUT - 1, RS_BUSY, 32'h77777777);
    model_done(is_data, 1'b0, RS_BUSY, TIMEOUT - 1, 32'h77777777); void'(exp_q.pop_front());
    n_checks++; if (g_hold_bad !== 0) begin n_fail++; $display("FAIL to_hold: %0d bad cycles before timeout want 0", g_hold_bad); end
    n_checks++; if (r_dhit !== 1'b1) begin n_fail++; $display("FAIL to_dhit: got %b want 1", r_dhit); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
    n_checks++; if (dload !== 32'hA5A50001) begin n_fail++; $display("FAIL to_dload: got %h want a5a50001", dload); end
    dREN = 0; dWEN = 1; daddr = 32'h30; dstore = 32'h5;
    model_grant(is_data); drive_txn(1, RS_ACC, 32'h0);
    model_done(is_data, 1'b1, RS_ACC, 1, 32'h0); void'(exp_q.pop_front());
    n_checks++; if (err !== 1'b1 || r_dhit !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got err=%b dhit=%b want 1/1", err, r_dhit); end
    dWEN = 0;
  endtask

  task automatic test_ram_error();
    logic is_data;
    do_reset();
    iREN = 1; iaddr = 32'h44;
    model_grant(is_data); drive_txn(0, RS_ERR, 32'hBAD0BAD0);
    model_done(is_data, 1'b0, RS_ERR, 0, 32'hBAD0BAD0); void'(exp_q.pop_front());
    n_checks++; if (r_ihit !== 1'b1 || r_dhit !== 1'b0) begin n_fail++; $display("FAIL err_ihit: got ihit=%b dhit=%b want 1/0", r_ihit, r_dhit); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", err); end
    n_checks++; if (iload !== 32'h0) begin n_fail++; $display("FAIL err_iload: got %h want 0", iload); end
    iREN = 0;
  endtask

  task automatic test_reset_mid_access();
    int hits;
    do_reset();
    iREN = 1; iaddr = 32'h100; ramstate = RS_FREE;
    @(posedge CLK); #1;
    n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin n_fail++; $display("FAIL mid_grant: got ren=%b addr=%h", ramREN, ramaddr); end
    ramstate = RS_BUSY;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if ({iload, dload, ramaddr, ramstore, ihit, dhit, ramREN, ramWEN, err} !== '0 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL mid_reset: got ren=%b ihit=%b state=%0d want all 0", ramREN, ihit, dbg_state); end
    RST = 1'b0; iREN = 0; ramstate = RS_ACC; ramload = 32'hFFFF0000;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (ihit !== 1'b0 || dhit !== 1'b0) hits++;
    end
    n_checks++; if (hits !== 0 || iload !== 32'h0) begin n_fail++; $display("FAIL mid_no_hit: got %0d hits iload=%h want 0/0", hits, iload); end
    ramstate = RS_FREE;
    model_reset();
  endtask

  task automatic test_random();
    logic is_data, is_wr;
    logic [1:0] fin;
    logic [31:0] rd, ea;
    int nb, r, op;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      iREN = (op == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dREN = (op == 1); dWEN = (op == 2);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; rd = $urandom;
      r = $urandom_range(0, 11);
      if (r == 0) begin nb = TIMEOUT - 1; fin = RS_BUSY; end
      else begin nb = $urandom_range(0, 5); fin = (r < 3) ? RS_ERR : RS_ACC; end
      model_grant(is_data);
      is_wr = is_data && dWEN;
      drive_txn(nb, fin, rd);
      model_done(is_data, is_wr, fin, nb, rd);
      ea = exp_q.pop_front();
      n_checks++; if (g_ren !== !is_wr || g_wen !== is_wr) begin n_fail++; $display("FAIL rnd_op[%0d]: got ren=%b wen=%b want wen=%b", t, g_ren, g_wen, is_wr); end
      n_checks++; if (g_addr !== ea) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", t, g_addr, ea); end
      n_checks++; if (g_store !== (is_wr ? dstore : 32'h0)) begin n_fail++; $display("FAIL rnd_store[%0d]: got %h want %h", t, g_store, is_wr ? dstore : 32'h0); end
      n_checks++; if (g_hold_bad !== 0) begin n_fail++; $display("FAIL rnd_hold[%0d]: %0d bad busy cycles", t, g_hold_bad); end
      n_checks++; if (r_dhit !== is_data || r_ihit !== !is_data || r_en !== 1'b0) begin
        n_fail++; $display("FAIL rnd_hit[%0d]: got dhit=%b ihit=%b en=%b want dhit=%b", t, r_dhit, r_ihit, r_en, is_data); end
      n_checks++; if (dload !== m_dload || iload !== m_iload) begin
        n_fail++; $display("FAIL rnd_loads[%0d]: got d=%h i=%h want d=%h i=%h", t, dload, iload, m_dload, m_iload); end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", t, err, m_err); end
      n_checks++; if (p_bad !== 1'b0) begin n_fail++; $display("FAIL rnd_idle[%0d]: activity in idle cycle after hit", t); end
      iREN = 0; dREN = 0; dWEN = 0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_data_read();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_ram_error();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case anything above stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
